// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: word width, control width
// and the opcode map driven by the ALU decoder.
package alu_pkg;

   localparam int WORD_LEN    = 32;
   localparam int EXE_CMD_LEN = 2;
   localparam int CTRL_W      = EXE_CMD_LEN + 1;

   typedef enum logic [2:0] {
      ALU_AND  = 3'b000,
      ALU_OR   = 3'b001,
      ALU_ADD  = 3'b010,
      ALU_XOR  = 3'b011,
      ALU_NOR  = 3'b100,
      ALU_SLTU = 3'b101,
      ALU_SUB  = 3'b110,
      ALU_SLT  = 3'b111
   } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the decode/issue side (master) and the ALU (slave).
interface alu_if #(
   parameter int WORD_LEN = alu_pkg::WORD_LEN,
   parameter int CTRL_W   = alu_pkg::CTRL_W
) ();
   import alu_pkg::*;

   logic [WORD_LEN-1:0] a;
   logic [WORD_LEN-1:0] b;
   logic [CTRL_W-1:0]   alucontrol;
   logic                in_valid;
   logic [WORD_LEN-1:0] result;
   logic                zero;
   logic                overflow;
   logic                out_valid;

   modport master (
      output a, b, alucontrol, in_valid,
      input  result, zero, overflow, out_valid
   );

   modport slave (
      input  a, b, alucontrol, in_valid,
      output result, zero, overflow, out_valid
   );

endinterface

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sum = a + (sub ? ~b + 1 : b), with carry-out and
// two's-complement overflow. Serves ADD, SUB, SLT and SLTU.
module alu_addsub #(
   parameter int WORD_LEN = alu_pkg::WORD_LEN
) (
   input  logic                 sub,
   input  logic [WORD_LEN-1:0]  a,
   input  logic [WORD_LEN-1:0]  b,
   output logic [WORD_LEN-1:0]  sum,
   output logic                 carry_out,
   output logic                 overflow
);
   import alu_pkg::*;

   logic [WORD_LEN-1:0] b_eff;
   logic [WORD_LEN:0]   full_sum;

   always_comb begin
      b_eff    = sub ? ~b : b;
      full_sum = {1'b0, a} + {1'b0, b_eff} + {{WORD_LEN{1'b0}}, sub};
   end

   assign sum       = full_sum[WORD_LEN-1:0];
   assign carry_out = full_sum[WORD_LEN];
   // Overflow when both adder inputs share a sign that the sum does not.
   assign overflow  = (a[WORD_LEN-1] == b_eff[WORD_LEN-1]) &&
                      (full_sum[WORD_LEN-1] != a[WORD_LEN-1]);

endmodule

// File: rtl/alu.sv
// 32-bit MIPS-style ALU with registered result, zero/overflow flags and a
// one-cycle valid pipeline in front of the EX/MEM boundary.
module alu #(
   parameter int WORD_LEN = alu_pkg::WORD_LEN,
   parameter int CTRL_W   = alu_pkg::CTRL_W
) (
   input  logic  clk,
   input  logic  rst_n,
   alu_if.slave  bus
);
   import alu_pkg::*;

   logic [CTRL_W-1:0]   op;
   logic                sub;
   logic [WORD_LEN-1:0] sum;
   logic                carry_out;
   logic                add_ovf;

   logic [WORD_LEN-1:0] res_comb;
   logic                ovf_comb;

   logic [WORD_LEN-1:0] result_d,    result_q;
   logic                zero_d,      zero_q;
   logic                overflow_d,  overflow_q;
   logic                out_valid_d, out_valid_q;

   assign op  = bus.alucontrol;
   assign sub = (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);

   alu_addsub #(.WORD_LEN(WORD_LEN)) u_addsub (
      .sub       (sub),
      .a         (bus.a),
      .b         (bus.b),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (add_ovf)
   );

   always_comb begin
      res_comb = '0;
      ovf_comb = 1'b0;
      case (op)
         ALU_AND:  res_comb = bus.a & bus.b;
         ALU_OR:   res_comb = bus.a | bus.b;
         ALU_ADD:  begin res_comb = sum; ovf_comb = add_ovf; end
         ALU_XOR:  res_comb = bus.a ^ bus.b;
         ALU_NOR:  res_comb = ~(bus.a | bus.b);
         // a - b borrows exactly when the carry-out of a + ~b + 1 is clear.
         ALU_SLTU: res_comb = {{(WORD_LEN-1){1'b0}}, ~carry_out};
         ALU_SUB:  begin res_comb = sum; ovf_comb = add_ovf; end
         // Overflow flips the sign of a - b, so XOR restores the true ordering.
         ALU_SLT:  res_comb = {{(WORD_LEN-1){1'b0}}, sum[WORD_LEN-1] ^ add_ovf};
      endcase
   end

   always_comb begin
      result_d    = result_q;
      zero_d      = zero_q;
      overflow_d  = overflow_q;
      out_valid_d = bus.in_valid;
      if (bus.in_valid) begin
         result_d   = res_comb;
         zero_d     = (res_comb == '0);
         overflow_d = ovf_comb;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q    <= '0;
         zero_q      <= 1'b1;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         result_q    <= result_d;
         zero_q      <= zero_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = overflow_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the registered ALU: directed opcode/boundary cases,
// asynchronous reset, back-to-back issue and hold, plus randomized traffic.
module tb_alu;

   localparam longint MAX_POS = 64'sd2147483647;
   localparam longint MIN_NEG = -64'sd2147483648;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   alu_if #(.WORD_LEN(32), .CTRL_W(3)) bus ();

   alu #(.WORD_LEN(32), .CTRL_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference computed straight from the opcode definitions with wide arithmetic.
   function automatic void ref_alu(input logic [2:0] op, input logic [31:0] x,
                                   input logic [31:0] y, output logic [31:0] r,
                                   output logic v);
      longint sx, sy, s;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      v  = 1'b0;
      r  = 32'd0;
      case (op)
         3'b000: r = x & y;
         3'b001: r = x | y;
         3'b010: begin s = sx + sy; r = x + y; v = (s > MAX_POS) || (s < MIN_NEG); end
         3'b011: r = x ^ y;
         3'b100: r = ~(x | y);
         3'b101: r = (x < y) ? 32'd1 : 32'd0;
         3'b110: begin s = sx - sy; r = x - y; v = (s > MAX_POS) || (s < MIN_NEG); end
         default: r = (sx < sy) ? 32'd1 : 32'd0;
      endcase
   endfunction

   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
      @(negedge clk);
      bus.a = x;
      bus.b = y;
      bus.alucontrol = op;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      issue(32'd7, 32'd9, 3'b010);
      tests++;
      if (bus.result !== 32'd16) begin
         fails++; $display("FAIL pre_reset_add: got %0d want 16", bus.result);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({bus.result, bus.zero, bus.overflow, bus.out_valid} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL async_reset: result=%h zero=%b ovf=%b vld=%b want 0/1/0/0",
                  bus.result, bus.zero, bus.overflow, bus.out_valid);
      end
      @(posedge clk);
      #1;
      tests++;
      if ({bus.result, bus.zero, bus.out_valid} !== {32'd0, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL reset_hold: result=%h zero=%b vld=%b want 0/1/0",
                  bus.result, bus.zero, bus.out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      issue(32'd15, 32'd10, 3'b010);
      tests++;
      if ({bus.result, bus.zero, bus.out_valid} !== {32'd25, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL post_reset_add: result=%0d zero=%b vld=%b want 25/0/1",
                  bus.result, bus.zero, bus.out_valid);
      end
   endtask

   // Directed table: a, b, op, expected result, expected overflow.
   task automatic run_table(input string name, input logic [31:0] ta[], input logic [31:0] tb_[],
                            input logic [2:0] top[], input logic [31:0] tr[], input logic tv[]);
      for (int i = 0; i < ta.size(); i++) begin
         issue(ta[i], tb_[i], top[i]);
         tests++;
         if (bus.result !== tr[i] || bus.overflow !== tv[i] ||
             bus.zero !== (tr[i] == 32'd0) || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s[%0d]: got res=%h ovf=%b zero=%b vld=%b want res=%h ovf=%b",
                     name, i, bus.result, bus.overflow, bus.zero, bus.out_valid, tr[i], tv[i]);
         end
      end
   endtask

   task automatic test_sub();
      run_table("sub", '{32'd15, 32'd10, 32'h8000_0000},
                       '{32'd10, 32'd10, 32'd1},
                       '{3'b110, 3'b110, 3'b110},
                       '{32'd5, 32'd0, 32'h7FFF_FFFF},
                       '{1'b0, 1'b0, 1'b1});
   endtask

   task automatic test_logic();
      run_table("logic", '{32'd12, 32'd12, 32'd12, 32'd0},
                         '{32'd5, 32'd5, 32'd5, 32'd0},
                         '{3'b000, 3'b001, 3'b011, 3'b100},
                         '{32'd4, 32'd13, 32'd9, 32'hFFFF_FFFF},
                         '{1'b0, 1'b0, 1'b0, 1'b0});
   endtask

   task automatic test_compare();
      run_table("compare", '{32'd5, 32'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF},
                           '{32'd12, 32'd5, 32'd1, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000},
                           '{3'b111, 3'b111, 3'b111, 3'b101, 3'b111, 3'b111},
                           '{32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0},
                           '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
   endtask

   task automatic test_add_overflow();
      run_table("add_ovf", '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF},
                           '{32'd1, 32'h8000_0000, 32'd1},
                           '{3'b010, 3'b010, 3'b010},
                           '{32'h8000_0000, 32'd0, 32'd0},
                           '{1'b1, 1'b1, 1'b0});
   endtask

   task automatic test_back_to_back();
      issue(32'd15, 32'd10, 3'b010);
      tests++;
      if (bus.result !== 32'd25 || bus.out_valid !== 1'b1) begin
         fails++; $display("FAIL b2b_add: result=%0d vld=%b want 25/1", bus.result, bus.out_valid);
      end
      issue(32'd12, 32'd5, 3'b001);
      tests++;
      if (bus.result !== 32'd13 || bus.out_valid !== 1'b1) begin
         fails++; $display("FAIL b2b_or: result=%0d vld=%b want 13/1", bus.result, bus.out_valid);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a = 32'h7FFF_FFFF;
      bus.b = 32'd1;
      bus.alucontrol = 3'b010;
      @(posedge clk);
      #1;
      tests++;
      if ({bus.result, bus.zero, bus.overflow, bus.out_valid} !== {32'd13, 1'b0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL hold: result=%0d zero=%b ovf=%b vld=%b want 13/0/0/0",
                  bus.result, bus.zero, bus.overflow, bus.out_valid);
      end
   endtask

   task automatic test_random();
      logic [31:0] edges[6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};
      logic [31:0] exp_r, x, y, r;
      logic        exp_v, exp_z, v, vld;
      logic [2:0]  op;
      exp_r = bus.result;
      exp_v = bus.overflow;
      exp_z = bus.zero;
      for (int i = 0; i < 300; i++) begin
         x   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
         y   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
         op  = 3'($urandom_range(0, 7));
         vld = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         bus.a = x;
         bus.b = y;
         bus.alucontrol = op;
         bus.in_valid = vld;
         @(posedge clk);
         #1;
         if (vld) begin
            ref_alu(op, x, y, r, v);
            exp_r = r;
            exp_v = v;
            exp_z = (r == 32'd0);
         end
         tests++;
         if (bus.result !== exp_r || bus.overflow !== exp_v || bus.zero !== exp_z ||
             bus.out_valid !== vld) begin
            fails++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h: got res=%h ovf=%b zero=%b vld=%b want res=%h ovf=%b zero=%b vld=%b",
                     i, op, x, y, bus.result, bus.overflow, bus.zero, bus.out_valid,
                     exp_r, exp_v, exp_z, vld);
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.alucontrol = '0;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({bus.result, bus.zero, bus.overflow, bus.out_valid} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL initial_reset: result=%h zero=%b ovf=%b vld=%b want 0/1/0/0",
                  bus.result, bus.zero, bus.overflow, bus.out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_sub();
      test_logic();
      test_compare();
      test_add_overflow();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
